pong_game_ctrl: RTL

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start/serve/play/point/game-over flow, scoring and
// frame-paced serve and post-point pauses. Every output comes straight from a flop.
module pong_game_ctrl #(
    parameter int SCORE_LIMIT  = 9,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 120
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_frame_tick,
    input  logic       i_start,
    input  logic       i_left_miss,
    input  logic       i_right_miss,
    output logic       o_ball_enable,
    output logic       o_ball_reset,
    output logic       o_serve_dir,
    output logic [3:0] o_left_score,
    output logic [3:0] o_right_score,
    output logic       o_game_over,
    output logic       o_winner,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] LIMIT      = 4'(SCORE_LIMIT);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] left_q, left_d;
    logic [3:0] right_q, right_d;
    logic       ball_enable_q, ball_enable_d;
    logic       ball_reset_q, ball_reset_d;
    logic       serve_dir_q, serve_dir_d;
    logic       game_over_q, game_over_d;
    logic       winner_q, winner_d;
    logic       start_prev_q, start_prev_d;
    logic       start_evt;
    logic [7:0] cnt_inc;

    assign start_evt = i_start & ~start_prev_q;
    assign cnt_inc   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    // NOTE: every _d gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        left_d       = left_q;
        right_d      = right_q;
        serve_dir_d  = serve_dir_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        ball_reset_d = 1'b0;
        start_prev_d = i_start;

        case (state_q)
            ST_IDLE: begin
                left_d  = 4'd0;
                right_d = 4'd0;
                if (start_evt) begin
                    state_d      = ST_SERVE;
                    cnt_d        = 8'd0;
                    serve_dir_d  = 1'b0;
                    ball_reset_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (i_frame_tick) begin
                    if (cnt_q == SERVE_LAST) state_d = ST_PLAY;
                    else                     cnt_d   = cnt_inc;
                end
            end
            ST_PLAY: begin
                if (i_left_miss || i_right_miss) begin
                    state_d = ST_POINT;
                    cnt_d   = 8'd0;
                    // Simultaneous misses cancel: pause, but nobody scores.
                    if (i_left_miss && !i_right_miss) begin
                        if (right_q != LIMIT) right_d = right_q + 4'd1;
                        serve_dir_d = 1'b0;
                    end else if (i_right_miss && !i_left_miss) begin
                        if (left_q != LIMIT) left_d = left_q + 4'd1;
                        serve_dir_d = 1'b1;
                    end
                end
            end
            ST_POINT: begin
                if (i_frame_tick) begin
                    if (cnt_q == POINT_LAST) begin
                        if (left_q == LIMIT || right_q == LIMIT) begin
                            state_d     = ST_OVER;
                            game_over_d = 1'b1;
                            winner_d    = (right_q == LIMIT);
                        end else begin
                            state_d      = ST_SERVE;
                            cnt_d        = 8'd0;
                            ball_reset_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_OVER: begin
                if (start_evt) begin
                    state_d      = ST_SERVE;
                    cnt_d        = 8'd0;
                    left_d       = 4'd0;
                    right_d      = 4'd0;
                    game_over_d  = 1'b0;
                    serve_dir_d  = 1'b0;
                    ball_reset_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ball_enable_d = (state_d == ST_PLAY);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            left_q        <= 4'd0;
            right_q       <= 4'd0;
            ball_enable_q <= 1'b0;
            ball_reset_q  <= 1'b0;
            serve_dir_q   <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 1'b0;
            start_prev_q  <= 1'b1; // a switch held high across reset is not a start
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            left_q        <= left_d;
            right_q       <= right_d;
            ball_enable_q <= ball_enable_d;
            ball_reset_q  <= ball_reset_d;
            serve_dir_q   <= serve_dir_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
            start_prev_q  <= start_prev_d;
        end
    end

    assign o_state       = state_q;
    assign o_left_score  = left_q;
    assign o_right_score = right_q;
    assign o_ball_enable = ball_enable_q;
    assign o_ball_reset  = ball_reset_q;
    assign o_serve_dir   = serve_dir_q;
    assign o_game_over   = game_over_q;
    assign o_winner      = winner_q;

endmodule
